// File: rtl/mem_pkg.sv
// Shared types and constants for the unified-RAM memory controller and its RAM.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_RMW_WRITE = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  localparam int unsigned RAM_WORDS     = 4096;
  localparam int unsigned LCD_BASE_WORD = 4092;
  localparam int unsigned KBD_WORD      = 4091;

endpackage

// File: rtl/lane_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension, and
// store merge of sub-word data into the previously read RAM word.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rd_word >> {lane, 3'b000};
    case (size)
      SIZE_B:  load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_H:  load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Halfword lanes are aligned by the error check, so lane[1] alone selects the half.
  always_comb begin
    store_word = rd_word;
    case (size)
      SIZE_B:  store_word[{lane, 3'b000} +: 8]           = wdata[7:0];
      SIZE_H:  store_word[{lane[1], 4'b0000} +: 16]      = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_controller.sv
// Sequences RV32I loads/stores onto a word-only RAM (read-modify-write for
// sub-word stores) and gates instruction fetch around same-word writes.
module mem_controller
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned BYTE_ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic [31:0]       instr,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [1:0]        data_size,
  input  logic              data_unsigned,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_ready,
  output logic [31:0]       data_rdata,
  output logic              data_err,
  output logic [ADDR_W-1:0] ram_addr_data,
  output logic [ADDR_W-1:0] ram_addr_instr,
  output logic [31:0]       ram_data_in,
  output logic              ram_we,
  input  logic [31:0]       ram_addr_out,
  input  logic [31:0]       ram_instr_out
);

  state_e            state, state_n;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lane_q;
  size_e             size_q;
  logic              uns_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic              fetch_ready_q;

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              word_store;
  logic              rmw_active;
  logic              fetch_blocked;
  logic [31:0]       load_data;
  logic [31:0]       merged;
  logic              unused_fetch_bits;

  assign unused_fetch_bits = ^{fetch_addr[31:BYTE_ADDR_W], fetch_addr[1:0]};

  assign accept = !rst && (state == S_IDLE) && data_req;

  always_comb begin
    misaligned = 1'b0;
    case (data_size)
      2'd1:    misaligned = data_addr[0];
      2'd2:    misaligned = |data_addr[1:0];
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  assign out_of_range = |data_addr[31:BYTE_ADDR_W];
  assign req_err      = misaligned | out_of_range;
  assign word_store   = accept && !req_err && data_we && (data_size == SIZE_W);
  assign rmw_active   = !rst && (state == S_RMW_WRITE);

  lane_align u_lane_align (
    .rd_word     (ram_addr_out),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        idx_q   <= data_addr[BYTE_ADDR_W-1:2];
        lane_q  <= data_addr[1:0];
        size_q  <= size_e'(data_size);
        uns_q   <= data_unsigned;
        err_q   <= req_err;
        wdata_q <= data_wdata;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                  state_n = S_DONE;
          else if (!data_we)            state_n = S_LOAD_WAIT;
          else if (data_size == SIZE_W) state_n = S_DONE;
          else                          state_n = S_RMW_WRITE;
        end
      end
      S_LOAD_WAIT: state_n = S_IDLE;
      S_RMW_WRITE: state_n = S_DONE;
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Every combinational output is gated by rst so an abandoned RMW cannot write on the reset edge.
  always_comb begin
    ram_addr_data = (state == S_IDLE) ? data_addr[BYTE_ADDR_W-1:2] : idx_q;
    ram_we        = word_store | rmw_active;
    ram_data_in   = '0;
    if (word_store)      ram_data_in = data_wdata;
    else if (rmw_active) ram_data_in = merged;
    data_ready    = !rst && ((state == S_LOAD_WAIT) || (state == S_DONE));
    data_err      = !rst && (state == S_DONE) && err_q;
    data_rdata    = (!rst && (state == S_LOAD_WAIT)) ? load_data : '0;
  end

  assign ram_addr_instr = fetch_addr[BYTE_ADDR_W-1:2];
  assign fetch_blocked  = ram_we && (ram_addr_instr == ram_addr_data);

  always_ff @(posedge clk) begin
    if (rst) fetch_ready_q <= 1'b0;
    else     fetch_ready_q <= fetch_req && !fetch_blocked;
  end

  assign fetch_ready = fetch_ready_q;
  assign instr       = fetch_ready_q ? ram_instr_out : '0;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with a behavioural dual-port RAM model.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] instr;
  logic        data_req;
  logic        data_we;
  logic [1:0]  data_size;
  logic        data_unsigned;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        data_err;
  logic [11:0] ram_addr_data;
  logic [11:0] ram_addr_instr;
  logic [31:0] ram_data_in;
  logic        ram_we;
  logic [31:0] ram_addr_out;
  logic [31:0] ram_instr_out;

  logic [31:0] mem [0:4095];
  int          we_cnt = 0;
  logic [11:0] last_idx;
  logic [31:0] last_data;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_controller #(.ADDR_W(12), .BYTE_ADDR_W(14)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_ready    (fetch_ready),
    .instr          (instr),
    .data_req       (data_req),
    .data_we        (data_we),
    .data_size      (data_size),
    .data_unsigned  (data_unsigned),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_ready     (data_ready),
    .data_rdata     (data_rdata),
    .data_err       (data_err),
    .ram_addr_data  (ram_addr_data),
    .ram_addr_instr (ram_addr_instr),
    .ram_data_in    (ram_data_in),
    .ram_we         (ram_we),
    .ram_addr_out   (ram_addr_out),
    .ram_instr_out  (ram_instr_out)
  );

  // RAM model: registered read on both ports, old data on a same-cycle write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_data] <= ram_data_in;
    ram_addr_out  <= mem[ram_addr_data];
    ram_instr_out <= mem[ram_addr_instr];
  end

  always @(posedge clk) begin
    if (ram_we) begin
      we_cnt    = we_cnt + 1;
      last_idx  = ram_addr_data;
      last_data = ram_data_in;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request held until data_ready (bounded), then released for one idle cycle.
  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int wdelta);
    int w0;
    w0 = we_cnt;
    data_req = 1'b1; data_we = we; data_size = sz; data_unsigned = uns;
    data_addr = a; data_wdata = wd;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!data_ready && lat < 8);
    rd = data_rdata;
    er = data_err;
    data_req = 1'b0;
    tick();
    wdelta = we_cnt - w0;
  endtask

  initial begin
    int          lat;
    int          wd;
    int          rdy;
    int          w0;
    logic [31:0] rd;
    logic        er;

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_size = 2'd0; data_unsigned = 1'b0;
    data_addr = '0; data_wdata = '0;
    repeat (3) tick();

    check("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    check("rst_data_ready",  {31'd0, data_ready},  32'd0);
    check("rst_data_err",    {31'd0, data_err},    32'd0);
    check("rst_ram_we",      {31'd0, ram_we},      32'd0);
    check("rst_data_rdata",  data_rdata,           32'd0);
    check("rst_instr",       instr,                32'd0);
    check("rst_ram_data_in", ram_data_in,          32'd0);
    rst = 1'b0;
    tick();

    // SW / LW round trip
    access(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er, wd);
    check("sw_lat", lat, 1);
    check("sw_we_count", wd, 1);
    check("sw_idx", {20'd0, last_idx}, 32'd64);
    check("sw_data", last_data, 32'hDEADBEEF);
    check("sw_err", {31'd0, er}, 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er, wd);
    check("lw_lat", lat, 1);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_no_write", wd, 0);

    // SB over 0x11223344 and sub-word loads
    access(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, lat, rd, er, wd);
    access(1'b1, 2'd0, 1'b0, 32'h102, 32'hFFFFFFAA, lat, rd, er, wd);
    check("sb_lat", lat, 2);
    check("sb_we_count", wd, 1);
    check("sb_idx", {20'd0, last_idx}, 32'd64);
    check("sb_merge", last_data, 32'h11AA3344);
    access(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, lat, rd, er, wd);
    check("lb_102", rd, 32'hFFFFFFAA);
    access(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, lat, rd, er, wd);
    check("lbu_102", rd, 32'h000000AA);
    access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, lat, rd, er, wd);
    check("lb_103", rd, 32'h00000011);
    access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, lat, rd, er, wd);
    check("lh_102", rd, 32'h000011AA);

    // SH ignores the upper half of wdata
    access(1'b1, 2'd1, 1'b0, 32'h100, 32'hFFFF8001, lat, rd, er, wd);
    check("sh_lat", lat, 2);
    check("sh_merge", last_data, 32'h11AA8001);
    access(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, lat, rd, er, wd);
    check("lh_100", rd, 32'hFFFF8001);
    access(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, lat, rd, er, wd);
    check("lhu_100", rd, 32'h00008001);

    // Error cases
    access(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, lat, rd, er, wd);
    check("lh_mis_err", {31'd0, er}, 32'd1);
    check("lh_mis_lat", lat, 1);
    check("lh_mis_rdata", rd, 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, lat, rd, er, wd);
    check("lw_oor_err", {31'd0, er}, 32'd1);
    check("lw_oor_rdata", rd, 32'd0);
    access(1'b1, 2'd2, 1'b0, 32'h102, 32'h12345678, lat, rd, er, wd);
    check("sw_mis_err", {31'd0, er}, 32'd1);
    check("sw_mis_no_write", wd, 0);
    access(1'b1, 2'd0, 1'b0, 32'h8000_0100, 32'h12, lat, rd, er, wd);
    check("sb_oor_no_write", wd, 0);
    access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, lat, rd, er, wd);
    check("size3_err", {31'd0, er}, 32'd1);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er, wd);
    check("lw_after_errs", rd, 32'h11AA8001);
    check("lw_after_errs_ok", {31'd0, er}, 32'd0);

    // Fetch, then a same-word store blocks the following fetch cycle
    fetch_req = 1'b1; fetch_addr = 32'h100;
    tick();
    check("fetch_ready", {31'd0, fetch_ready}, 32'd1);
    check("fetch_instr", instr, 32'h11AA8001);
    data_req = 1'b1; data_we = 1'b1; data_size = 2'd2; data_unsigned = 1'b0;
    data_addr = 32'h100; data_wdata = 32'hCAFEF00D;
    #1;
    check("hz_we", {31'd0, ram_we}, 32'd1);
    tick();
    check("hz_blocked", {31'd0, fetch_ready}, 32'd0);
    check("hz_store_ready", {31'd0, data_ready}, 32'd1);
    data_req = 1'b0;
    tick();
    check("hz_retry_ready", {31'd0, fetch_ready}, 32'd1);
    check("hz_retry_instr", instr, 32'hCAFEF00D);

    // Store to a different word does not block the fetch
    fetch_addr = 32'h108;
    access(1'b1, 2'd2, 1'b0, 32'h104, 32'h0BADF00D, lat, rd, er, wd);
    check("nohz_fetch", {31'd0, fetch_ready}, 32'd1);
    fetch_req = 1'b0;
    tick();
    check("fetch_idle", {31'd0, fetch_ready}, 32'd0);
    check("fetch_idle_instr", instr, 32'd0);

    // Reset in RMW_WRITE abandons the store
    data_req = 1'b1; data_we = 1'b1; data_size = 2'd0; data_unsigned = 1'b0;
    data_addr = 32'h101; data_wdata = 32'h55;
    tick();
    check("rmw_we_pre", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("rmw_rst_we", {31'd0, ram_we}, 32'd0);
    check("rmw_rst_din", ram_data_in, 32'd0);
    check("rmw_rst_ready", {31'd0, data_ready}, 32'd0);
    w0 = we_cnt;
    tick();
    data_req = 1'b0;
    check("rmw_rst_no_write", we_cnt - w0, 0);
    check("rmw_rst_rdata", data_rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_we", {31'd0, ram_we}, 32'd0);
    check("post_rst_ready", {31'd0, data_ready}, 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er, wd);
    check("post_rst_lw_lat", lat, 1);
    check("post_rst_lw", rd, 32'hCAFEF00D);

    // LW with data_req held across ready: one pulse per two cycles
    data_req = 1'b1; data_we = 1'b0; data_size = 2'd2; data_addr = 32'h104;
    rdy = 0;
    w0 = we_cnt;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (data_ready) begin
        rdy++;
        check("held_lw_rdata", data_rdata, 32'h0BADF00D);
      end
    end
    data_req = 1'b0;
    tick();
    check("held_lw_pulses", rdy, 3);
    check("held_lw_no_write", we_cnt - w0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Sequences CPU load/store traffic onto the word-only, 4096x32 unified RAM and gates instruction fetch around it.
- Converts RV32I byte/halfword/word accesses into word operations: lane extraction plus sign/zero extension on loads, read-modify-write on sub-word stores.
- Detects misaligned and out-of-range accesses.
- Sits between the core's fetch/LSU stage and the RAM's data and instruction ports.

Parameters:
- ADDR_W, 12, RAM word-address width (depth 2**ADDR_W words).
- BYTE_ADDR_W, 14, byte-address bits that map to RAM (ADDR_W+2); higher set bits are out of range.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- fetch_req  input  1  instruction fetch request
- fetch_addr  input  32  fetch byte address (word aligned)
- fetch_ready  output  1  instr valid this cycle
- instr  output  32  fetched instruction
- data_req  input  1  load/store request; held until data_ready
- data_we  input  1  1=store, 0=load
- data_size  input  2  0=byte, 1=half, 2=word
- data_unsigned  input  1  zero-extend load (LBU/LHU)
- data_addr  input  32  data byte address
- data_wdata  input  32  store data (low-aligned)
- data_ready  output  1  one-cycle completion pulse
- data_rdata  output  32  extended load result
- data_err  output  1  qualifies data_ready: misaligned or out-of-range
- ram_addr_data  output  12  RAM data-port word address
- ram_addr_instr  output  12  RAM instruction-port word address
- ram_data_in  output  32  RAM write data
- ram_we  output  1  RAM write enable
- ram_addr_out  input  32  RAM data-port read word (registered, 1-cycle latency)
- ram_instr_out  input  32  RAM instruction-port read word (registered, 1-cycle latency)

Behaviour:
- Reset (synchronous, active-high): state=IDLE.
  - fetch_ready, data_ready, data_err, ram_we = 0.
  - data_rdata, instr, ram_data_in = 0.
  - Latched address/size/data registers = 0.
  - Reset mid-operation abandons the access; no write occurs after the reset cycle.
- Word index = addr[13:2]; byte lane = addr[1:0].
- States:
  - IDLE: accept data_req.
  - LOAD_WAIT: load result cycle.
  - RMW_WRITE: merged write cycle.
  - DONE: completion pulse.
- IDLE with data_req:
  - ram_addr_data = data_addr[13:2], combinational.
  - Latch addr/size/unsigned/wdata.
  - If the error check passes, take the normal path below.
  - On error: no RAM write, go to DONE with data_err=1 and data_rdata=0.
- Error check:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr[31:14]!=0.
  - data_size=3 is treated as misaligned.
- Load (error check passed): next state LOAD_WAIT.
  - In LOAD_WAIT: data_ready=1 and data_rdata = lane extracted from ram_addr_out, sign-extended unless data_unsigned.
  - Load latency is 1 cycle after acceptance.
- Word store (error check passed): ram_we=1 and ram_data_in=data_wdata in the accept cycle, then DONE.
  - Ready 1 cycle after acceptance.
- Sub-word store (error check passed): no write in the accept cycle (the read is issued); go to RMW_WRITE.
  - In RMW_WRITE: ram_data_in = ram_addr_out with the addressed lane(s) replaced by data_wdata[7:0] / [15:0]; ram_we=1; ram_addr_data = latched index. Then DONE.
  - Ready 2 cycles after acceptance.
- LOAD_WAIT and DONE return to IDLE. A data_req still high in the ready cycle is not re-accepted; the next request is accepted earliest in the following cycle.
- Fetch:
  - ram_addr_instr = fetch_addr[13:2], combinational, always driven.
  - fetch_ready is registered: high the cycle after fetch_req was sampled high and not blocked.
  - instr = ram_instr_out in that cycle.
- Fetch/write hazard: if ram_we=1 and the fetch word index equals the write index in the same cycle, the fetch is blocked. fetch_ready stays 0 next cycle, and the core holds fetch_req, which re-reads the updated word.
- Fetch and data accesses otherwise proceed concurrently.
- ram_we is asserted only in an accepted, error-free word-store IDLE cycle or in RMW_WRITE; at most one cycle per store.

Decomposition:
- Package mem_pkg:
  - size enum (SIZE_B, SIZE_H, SIZE_W).
  - State enum.
  - Constant RAM_WORDS = 4096.
  - MMIO constants LCD_BASE_WORD = 4092 and KBD_WORD = 4091, shared with the RAM.
- One combinational sub-module, lane_align, provides:
  - Load extract/extend from (word, lane, size, unsigned).
  - Store merge from (old word, wdata, lane, size).

Test Plan:
- SW 0xDEADBEEF to 0x100, then LW 0x100: ram_we for exactly 1 cycle at index 64; the load returns data_ready after 1 cycle with data_rdata=0xDEADBEEF.
- SB 0xAA to 0x102 over word 0x11223344: RMW writes 0x11AA3344; ready in cycle 2. Then LB 0x102 returns 0xFFFFFFAA and LBU 0x102 returns 0x000000AA.
- LH at 0x103: data_err=1 with data_ready, no ram_we, data_rdata=0. LW at 0x4000 (out of range) behaves the same way.
- Fetch of word 64 in the same cycle as a SW to word 64: fetch_ready=0 next cycle; on retry instr=new store data.
- Reset asserted in the RMW_WRITE cycle: no ram_we at or after the reset edge; all outputs 0; the next request completes normally.
- data_req held high across data_ready for a LW: exactly one RAM read and one ready pulse per 2-cycle window.
